ex_mem_pipe_nlane: RTL
======================

Name: ex_mem_pipe_nlane

Overview:
- Parametrised EX/MEM pipeline register for an N-lane in-order superscalar core; one instance replaces all per-lane EX/MEM registers.
- Registers each lane's ALU result, store data, destination register, PC, PC-plus and memory/writeback controls. Adds valid bits, a MEM-side stall (hold), and per-lane flush that also kills all younger lanes.
- Squashes intra-bundle write-after-write register writes so writeback sees at most one writer per register.

Parameters:
- LANES, 2, issue lanes; lane 0 is oldest in program order.
- DATA_W, 32, ALU result and store data width.
- REG_W, 5, register index width.
- PC_W, 8, PC and PC-plus width.
- M2R_W, 2, MemtoReg select width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- stall_M  in  1  hold all MEM-stage contents
- flush_E  in  LANES  per-lane kill of the EX instruction being loaded
- valid_E  in  LANES  lane carries a real instruction
- alu_out_E  in  LANES*DATA_W  ALU results, lane i at [i*DATA_W +: DATA_W]
- wdata_E  in  LANES*DATA_W  store data
- dest_E  in  LANES*REG_W  destination register
- pc_E, pcplus_E  in  LANES*PC_W  instruction PC and PC-plus
- mem_rd_E, mem_wr_E, reg_wr_E  in  LANES  control enables
- mem2reg_E  in  LANES*M2R_W  writeback select
- valid_M, alu_out_M, wdata_M, dest_M, pc_M, pcplus_M, mem_rd_M, mem_wr_M, reg_wr_M, mem2reg_M  out  (same widths)  registered MEM-stage copies

Behaviour:
- Reset (asynchronous, active-low, highest priority): every output is 0, including all data, PC, dest, control and valid bits.
- Latency: 1 cycle. Outputs are registered only; no combinational input-to-output path.
- Per-clock priority: reset, then stall_M, then load.
- stall_M=1: all outputs hold. flush_E is ignored, because the held MEM contents are older than the EX instruction. The upstream stage must hold flush_E asserted until the stall releases.
- Kill mask on load: lane i is killed if flush_E[j]=1 for any j<=i. A flush of an older lane therefore kills every younger lane.
- Killed lane or valid_E[i]=0: valid_M[i], mem_rd_M[i], mem_wr_M[i] and reg_wr_M[i] load 0. alu_out, wdata, dest, pc, pcplus and mem2reg load 0.
- Surviving lane: all fields load from the E inputs, and valid_M[i]=1.
- x0 rule: reg_wr_M[i] loads 0 when dest_E[i]==0, even if reg_wr_E[i]=1.
- WAW squash: if surviving lanes i<j both have reg_wr_E=1 and the same nonzero dest, reg_wr_M[i] loads 0. The younger write wins. Lane i's valid, mem_rd and mem_wr are unaffected, so a load still accesses memory.
- Flush and stall asserted together: stall wins; nothing changes.
- Reset deasserting mid-stall: outputs stay 0 until the first load edge.

Optional Feature:
- Macro: EX_MEM_PERF_CNT_EN.
- Defined: adds outputs kill_cnt (32-bit) and stall_cnt (32-bit).
  - kill_cnt increments, on each load edge, by the number of lanes killed while valid_E=1.
  - stall_cnt increments by 1 on each edge with stall_M=1.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package ex_mem_pkg holds:
  - MemtoReg encodings (M2R_ALU=0, M2R_MEM=1, M2R_PC=2).
  - Default width localparams.
  - Struct typedef ex_mem_lane_t bundling the per-lane fields.
- Sub-module ex_mem_lane_reg: a single-lane register with hold, kill and reg_wr-squash inputs, instantiated LANES times.
- Kill-mask and WAW-compare logic live in the top level.

Test Plan:
- Reset while valid data is loaded: assert reset low mid-cycle -> all outputs 0 immediately, before any clock edge.
- Normal load: lane0 alu=0x11, dest=3, reg_wr=1 and lane1 alu=0x22, dest=4, reg_wr=1 -> next edge gives valid_M=2'b11 with exact values.
- Older flush: flush_E=2'b01 with both lanes valid -> valid_M=2'b00 and all lane1 fields 0.
- Younger flush: flush_E=2'b10 -> valid_M=2'b01; lane0 fields loaded, lane1 zero.
- Stall over flush: stall_M=1 for 3 cycles with flush_E=2'b11 -> outputs unchanged; release stall with flush_E=0 -> new data loads.
- WAW and x0: both lanes write dest=7 -> reg_wr_M=2'b10. Lane0 dest=0 with reg_wr=1 -> reg_wr_M[0]=0 while valid_M[0]=1.
- With EX_MEM_PERF_CNT_EN: after the flush 2'b01 case plus 3 stall cycles -> kill_cnt=2, stall_cnt=3.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared definitions for the N-lane EX/MEM pipeline register:
// default widths, MemtoReg encodings and the per-lane field bundle.
package ex_mem_pkg;

  localparam int DEF_LANES  = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_PC_W   = 8;
  localparam int DEF_M2R_W  = 2;

  typedef enum logic [DEF_M2R_W-1:0] {
    M2R_ALU = 2'd0,
    M2R_MEM = 2'd1,
    M2R_PC  = 2'd2
  } mem2reg_e;

  // One lane's MEM-stage contents at the default widths.
  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] aluOut;
    logic [DEF_DATA_W-1:0] wdata;
    logic [DEF_REG_W-1:0]  dest;
    logic [DEF_PC_W-1:0]   pc;
    logic [DEF_PC_W-1:0]   pcplus;
    logic                  memRd;
    logic                  memWr;
    logic                  regWr;
    mem2reg_e              mem2reg;
  } ex_mem_lane_t;

endpackage

// File: rtl/ex_mem_lane_reg.sv
// Single-lane EX/MEM register: holds on hold, loads zeros when killed or
// empty, and drops the register write for x0 or a squashed WAW writer.
module ex_mem_lane_reg
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int M2R_W  = DEF_M2R_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              kill,
  input  logic              squashWr,
  input  logic              validIn,
  input  logic [DATA_W-1:0] aluIn,
  input  logic [DATA_W-1:0] wdataIn,
  input  logic [REG_W-1:0]  destIn,
  input  logic [PC_W-1:0]   pcIn,
  input  logic [PC_W-1:0]   pcplusIn,
  input  logic              memRdIn,
  input  logic              memWrIn,
  input  logic              regWrIn,
  input  logic [M2R_W-1:0]  mem2regIn,
  output logic              validOut,
  output logic [DATA_W-1:0] aluOut,
  output logic [DATA_W-1:0] wdataOut,
  output logic [REG_W-1:0]  destOut,
  output logic [PC_W-1:0]   pcOut,
  output logic [PC_W-1:0]   pcplusOut,
  output logic              memRdOut,
  output logic              memWrOut,
  output logic              regWrOut,
  output logic [M2R_W-1:0]  mem2regOut
);

  logic loadLane;
  assign loadLane = validIn && !kill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      validOut   <= 1'b0;
      aluOut     <= '0;
      wdataOut   <= '0;
      destOut    <= '0;
      pcOut      <= '0;
      pcplusOut  <= '0;
      memRdOut   <= 1'b0;
      memWrOut   <= 1'b0;
      regWrOut   <= 1'b0;
      mem2regOut <= '0;
    end else if (!hold) begin
      if (loadLane) begin
        validOut   <= 1'b1;
        aluOut     <= aluIn;
        wdataOut   <= wdataIn;
        destOut    <= destIn;
        pcOut      <= pcIn;
        pcplusOut  <= pcplusIn;
        memRdOut   <= memRdIn;
        memWrOut   <= memWrIn;
        // x0 is never written; a younger same-dest writer in the bundle wins.
        regWrOut   <= regWrIn && (destIn != '0) && !squashWr;
        mem2regOut <= mem2regIn;
      end else begin
        validOut   <= 1'b0;
        aluOut     <= '0;
        wdataOut   <= '0;
        destOut    <= '0;
        pcOut      <= '0;
        pcplusOut  <= '0;
        memRdOut   <= 1'b0;
        memWrOut   <= 1'b0;
        regWrOut   <= 1'b0;
        mem2regOut <= '0;
      end
    end
  end

endmodule

// File: rtl/ex_mem_pipe_nlane.sv
// N-lane EX/MEM pipeline register with stall, cascading flush and WAW squash.
// Optional EX_MEM_PERF_CNT_EN adds kill_cnt / stall_cnt performance counters.
module ex_mem_pipe_nlane
  import ex_mem_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int M2R_W  = DEF_M2R_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall_M,
  input  logic [LANES-1:0]          flush_E,
  input  logic [LANES-1:0]          valid_E,
  input  logic [LANES*DATA_W-1:0]   alu_out_E,
  input  logic [LANES*DATA_W-1:0]   wdata_E,
  input  logic [LANES*REG_W-1:0]    dest_E,
  input  logic [LANES*PC_W-1:0]     pc_E,
  input  logic [LANES*PC_W-1:0]     pcplus_E,
  input  logic [LANES-1:0]          mem_rd_E,
  input  logic [LANES-1:0]          mem_wr_E,
  input  logic [LANES-1:0]          reg_wr_E,
  input  logic [LANES*M2R_W-1:0]    mem2reg_E,
  output logic [LANES-1:0]          valid_M,
  output logic [LANES*DATA_W-1:0]   alu_out_M,
  output logic [LANES*DATA_W-1:0]   wdata_M,
  output logic [LANES*REG_W-1:0]    dest_M,
  output logic [LANES*PC_W-1:0]     pc_M,
  output logic [LANES*PC_W-1:0]     pcplus_M,
  output logic [LANES-1:0]          mem_rd_M,
  output logic [LANES-1:0]          mem_wr_M,
  output logic [LANES-1:0]          reg_wr_M,
  output logic [LANES*M2R_W-1:0]    mem2reg_M
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]               kill_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  // Stage handshake: stall_M=1 freezes every MEM lane and ignores flush_E
  // (held contents are older); flush_E and valid_E act only on load edges.

  logic [LANES-1:0] killMask;
  logic [LANES-1:0] survive;
  logic [LANES-1:0] wawSquash;
  logic             flushSeen;

  // A flush on any older-or-equal lane kills this lane.
  always_comb begin
    killMask  = '0;
    flushSeen = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      flushSeen   = flushSeen | flush_E[i];
      killMask[i] = flushSeen;
    end
  end

  assign survive = valid_E & ~killMask;

  always_comb begin
    wawSquash = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (survive[i] && survive[j] && reg_wr_E[i] && reg_wr_E[j] &&
            (dest_E[i*REG_W +: REG_W] == dest_E[j*REG_W +: REG_W]) &&
            (dest_E[i*REG_W +: REG_W] != '0)) begin
          wawSquash[i] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ex_mem_lane_reg #(
      .DATA_W (DATA_W),
      .REG_W  (REG_W),
      .PC_W   (PC_W),
      .M2R_W  (M2R_W)
    ) u_lane_reg (
      .clk        (clk),
      .reset      (reset),
      .hold       (stall_M),
      .kill       (killMask[g]),
      .squashWr   (wawSquash[g]),
      .validIn    (valid_E[g]),
      .aluIn      (alu_out_E[g*DATA_W +: DATA_W]),
      .wdataIn    (wdata_E[g*DATA_W +: DATA_W]),
      .destIn     (dest_E[g*REG_W +: REG_W]),
      .pcIn       (pc_E[g*PC_W +: PC_W]),
      .pcplusIn   (pcplus_E[g*PC_W +: PC_W]),
      .memRdIn    (mem_rd_E[g]),
      .memWrIn    (mem_wr_E[g]),
      .regWrIn    (reg_wr_E[g]),
      .mem2regIn  (mem2reg_E[g*M2R_W +: M2R_W]),
      .validOut   (valid_M[g]),
      .aluOut     (alu_out_M[g*DATA_W +: DATA_W]),
      .wdataOut   (wdata_M[g*DATA_W +: DATA_W]),
      .destOut    (dest_M[g*REG_W +: REG_W]),
      .pcOut      (pc_M[g*PC_W +: PC_W]),
      .pcplusOut  (pcplus_M[g*PC_W +: PC_W]),
      .memRdOut   (mem_rd_M[g]),
      .memWrOut   (mem_wr_M[g]),
      .regWrOut   (reg_wr_M[g]),
      .mem2regOut (mem2reg_M[g*M2R_W +: M2R_W])
    );
  end

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] killedNow;

  // Only lanes that carried a real instruction count as killed.
  always_comb begin
    killedNow = '0;
    for (int i = 0; i < LANES; i++) begin
      killedNow = killedNow + 32'(killMask[i] & valid_E[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kill_cnt  <= '0;
      stall_cnt <= '0;
    end else if (stall_M) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      kill_cnt  <= kill_cnt + killedNow;
    end
  end
`endif

endmodule
